mem_responder: RTL
==================

# mem_responder

Memory-side responder for the accumulator CPU's fetch/load/store bus. It holds byte-addressed program and data storage and answers one 16-bit word request at a time through a valid/ready request channel and a single-cycle response pulse, with a configurable number of wait states. A separate byte loader port lets benches and boot logic preload programs, for example the Fibonacci loop of Load/Add/Store/Skip/Jump words at 0x00–0x1E.

## Interface
- `MEM_SIZE`, 65536: storage size in bytes; must be even and ≤ 2^`ADDR_W`.
- `ADDR_W`, 16: byte address width.
- `WAIT_CYCLES`, 2: wait states between request acceptance and response (0–15).
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept a request.
- `req_we` in 1: 1 = store word, 0 = read word.
- `req_addr` in `ADDR_W`: byte address of the word.
- `req_wdata` in 16: store data.
- `resp_valid` out 1: one-cycle response pulse.
- `resp_rdata` out 16: read data; 0x0000 for writes and errors.
- `resp_err` out 1: request was misaligned or out of range.
- `ld_en` in 1: loader byte write strobe.
- `ld_addr` in `ADDR_W`: loader byte address.
- `ld_data` in 8: loader byte.

## Operation
- Byte order is big-endian: word at even `a` = {MEM[a], MEM[a+1]}. Word 0x0324 at 0x00 means MEM[0x00]=0x03 and MEM[0x01]=0x24.
- FSM states:
  - IDLE: `req_ready`=1. If `req_valid` is high, the request is accepted; go to WAIT, or to RESP when `WAIT_CYCLES`=0.
  - WAIT: count down `WAIT_CYCLES`−1 … 0, then go to RESP.
  - RESP: `resp_valid`=1 for exactly one cycle, then go to IDLE.
- On the acceptance edge:
  - The request is checked. An error is `req_addr[0]`=1 or `req_addr` ≥ `MEM_SIZE`−1.
  - An error commits no write and latches `resp_err`=1.
  - A valid store writes both bytes at this edge.
  - A valid read latches the word at this edge.
- Latched outputs are held stable from the acceptance edge until the next acceptance. Consumers must sample only while `resp_valid`=1.
- There is no response backpressure; the initiator must take the pulse.
- Loader: `ld_en` writes `ld_data` to MEM[`ld_addr`] on any cycle and in any FSM state.
  - Ignored if `ld_addr` ≥ `MEM_SIZE`.
  - If the loader and an accepted store hit the same byte on the same edge, the loader wins.
- Memory contents are not cleared by reset.

## Timing
- Reset values: `req_ready`=0 while `rst`=1, then 1. `resp_valid`=0, `resp_rdata`=0x0000, `resp_err`=0, state IDLE, counter 0.
- Acceptance at edge N → `resp_valid` high in cycle N+1+`WAIT_CYCLES`.
- `req_ready` is low from cycle N+1 through the RESP cycle, and high again the cycle after RESP.
- Throughput is one request per `WAIT_CYCLES`+2 cycles.
- A read accepted at the same edge as a loader write to an addressed byte returns the old byte.
- Reset in WAIT or RESP:
  - The pending response is dropped, with no `resp_valid`.
  - A store already committed at acceptance remains in memory.
- `req_valid` outside IDLE is ignored, not queued.

## Structure
- Shared package `cpu_pkg` holds:
  - state enum (IDLE, WAIT, RESP);
  - word width 16;
  - opcode constants HALT=0x0, ADD=0x1, LOAD=0x3, STORE=0x4, SKIP=0x6, JUMP=0x7, shared with the CPU decoder.
- Sub-module `mem_byte_array` holds byte storage with one word-read/word-write port and one byte write port for the loader, plus loader priority.
- The FSM and wait-state counter live in `mem_responder`.

## Test plan
- Load 0x03@0x00 and 0x24@0x01 via the loader, `WAIT_CYCLES`=2, read 0x0000 accepted at edge N → `resp_valid` only in cycle N+3, `resp_rdata`=0x0324, `resp_err`=0.
- Store 0x0005 @0x0024, then read 0x0024 → 0x0005; MEM[0x24]=0x00 and MEM[0x25]=0x05.
- Read 0x0003 (misaligned) → `resp_err`=1, `resp_rdata`=0x0000. Store 0xBEEF @0xFFFF → `resp_err`=1 and memory unchanged.
- Hold `req_valid`=1 continuously with `WAIT_CYCLES`=0 → one `resp_valid` every 2 cycles, and `req_ready` toggles 1/0.
- Store 0x1234 @0x0010 with `ld_en` writing 0xAA@0x0010 on the same edge → subsequent read returns 0xAA34.
- Assert `rst` during WAIT of a store of 0x0700 @0x001C → no `resp_valid`, outputs at reset values, and a later read of 0x001C returns 0x0700.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU and its memory-side responder.
package cpu_pkg;

    localparam int unsigned WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Opcode nibble values, shared with the CPU decoder.
    localparam logic [3:0] HALT  = 4'h0;
    localparam logic [3:0] ADD   = 4'h1;
    localparam logic [3:0] LOAD  = 4'h3;
    localparam logic [3:0] STORE = 4'h4;
    localparam logic [3:0] SKIP  = 4'h6;
    localparam logic [3:0] JUMP  = 4'h7;

endpackage

// File: rtl/mem_byte_array.sv
// Byte storage, big-endian word read/write port plus a loader byte port.
module mem_byte_array
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_SIZE = 65536,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  word_t             wdata,
    output word_t             rdata,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data
);

    localparam int unsigned IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

    logic [7:0]       mem [MEM_SIZE];
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;
    logic [IDX_W-1:0] ld_idx;
    logic             addr_ok;
    logic             ld_ok;

    // Word port is only used with even addresses, so the low byte sits at addr|1.
    assign hi_idx  = addr[IDX_W-1:0];
    assign lo_idx  = hi_idx | IDX_W'(1);
    assign ld_idx  = ld_addr[IDX_W-1:0];
    assign addr_ok = 32'(addr) < MEM_SIZE - 1;
    assign ld_ok   = 32'(ld_addr) < MEM_SIZE;

    assign rdata = addr_ok ? {mem[hi_idx], mem[lo_idx]} : '0;

    // Loader write is issued last so it wins a same-byte collision with a store.
    always_ff @(posedge clk) begin
        if (wr_en && addr_ok) begin
            mem[hi_idx] <= wdata[15:8];
            mem[lo_idx] <= wdata[7:0];
        end
        if (ld_en && ld_ok) begin
            mem[ld_idx] <= ld_data;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: valid/ready word requests, fixed wait states, one-cycle response.
module mem_responder
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_SIZE    = 65536,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    output logic              resp_valid,
    output logic [15:0]       resp_rdata,
    output logic              resp_err,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data
);

    localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t     state;
    state_t     state_nx;
    logic [3:0] cnt;
    logic [3:0] cnt_nx;
    logic       accept;
    logic       req_err;
    word_t      mem_rdata;

    assign accept  = req_ready & req_valid;
    assign req_err = req_addr[0] | (32'(req_addr) >= MEM_SIZE - 1);

    mem_byte_array #(
        .MEM_SIZE (MEM_SIZE),
        .ADDR_W   (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (accept & req_we & ~req_err),
        .addr    (req_addr),
        .wdata   (req_wdata),
        .rdata   (mem_rdata),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = (WAIT_CYCLES == 0) ? RESP : WAIT;
                    cnt_nx   = WAIT_LAST;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nx = RESP;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE) & ~rst;
        resp_valid = (state == RESP);
    end

    // Response data is captured at acceptance and held until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (accept) begin
            resp_err   <= req_err;
            resp_rdata <= (req_err || req_we) ? 16'h0000 : mem_rdata;
        end
    end

endmodule
